// File: rtl/wb_resp_regfile.sv
// Wishbone responder register block: CTRL, DATA, CMD/STATUS and ID registers with a countdown job engine.
// Optional macro WB_RESP_STRICT_RO_EN: writes to the ID register return err_o instead of ack_o.
module wb_resp_regfile #(
   parameter int          ADDR_WIDTH  = 2,
   parameter int          DATA_WIDTH  = 8,
   parameter int          WAIT_STATES = 0,
   parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cyc_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] adr_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic                  ack_o,
   output logic                  irq_o
`ifdef WB_RESP_STRICT_RO_EN
   ,output logic                 err_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            commit;
   logic            req;
   logic            wr, rd, ro_err;
   logic [1:0]      a;

   logic            en_q, en_d, ie_q, ie_d;
   logic [7:0]      data_q, data_d;
   logic            bsy_q, bsy_d, don_q, don_d, errf_q, errf_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [7:0]      dat_q, dat_d;
   logic            ack_q, irq_q, erro_q;

   assign req = cyc_i & stb_i;
   assign a   = adr_i[1:0];
   assign wr  = commit & we_i;
   assign rd  = commit & ~we_i;

`ifdef WB_RESP_STRICT_RO_EN
   assign ro_err = wr & (a == 2'd3);
   assign err_o  = erro_q;
`else
   assign ro_err = 1'b0;
`endif

   // Handshake: commit happens on the edge that moves the FSM into S_ACK
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = 4'(WAIT_STATES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (wcnt_q == 4'd0) begin
               state_d = S_ACK;
               commit  = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         S_ACK:  state_d = S_HOLD;
         S_HOLD: if (!stb_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Register file and job engine; a completing job's DON set overrides a STATUS-read clear
   always_comb begin
      en_d   = en_q;
      ie_d   = ie_q;
      data_d = data_q;
      bsy_d  = bsy_q;
      don_d  = don_q;
      errf_d = errf_q;
      cnt_d  = cnt_q;
      dat_d  = dat_q;

      if (rd && a == 2'd2) begin
         don_d  = 1'b0;
         errf_d = 1'b0;
      end

      if (bsy_q) begin
         if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
         end else begin
            bsy_d = 1'b0;
            don_d = 1'b1;
         end
      end

      if (wr) begin
         case (a)
            2'd0: begin
               en_d = dat_i[7];
               ie_d = dat_i[6];
               if (!dat_i[7] && bsy_q) begin
                  bsy_d = 1'b0;
                  cnt_d = 5'd0;
                  don_d = don_q;
               end
            end
            2'd1: data_d = dat_i;
            2'd2: begin
               if (en_q && !bsy_q) begin
                  bsy_d = 1'b1;
                  cnt_d = dat_i[4:0];
               end else begin
                  errf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (rd) begin
         case (a)
            2'd0:    dat_d = {en_q, ie_q, 6'b0};
            2'd1:    dat_d = data_q;
            2'd2:    dat_d = {don_q, bsy_q, errf_q, cnt_q};
            default: dat_d = ID_VALUE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wcnt_q  <= 4'd0;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         data_q  <= 8'd0;
         bsy_q   <= 1'b0;
         don_q   <= 1'b0;
         errf_q  <= 1'b0;
         cnt_q   <= 5'd0;
         dat_q   <= 8'd0;
         ack_q   <= 1'b0;
         irq_q   <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         data_q  <= data_d;
         bsy_q   <= bsy_d;
         don_q   <= don_d;
         errf_q  <= errf_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         ack_q   <= commit & ~ro_err;
         irq_q   <= don_q & ie_q;
         erro_q  <= ro_err;
      end
   end

   assign dat_o = dat_q;
   assign ack_o = ack_q;
   assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_resp_regfile.sv
// Directed bench for wb_resp_regfile: one instance with WAIT_STATES=0, one with WAIT_STATES=3.
module tb_wb_resp_regfile;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, we;
   logic [1:0] adr;
   logic [7:0] dat;
   logic       cyc0, stb0, cyc3, stb3;
   logic [7:0] dato0, dato3;
   logic       ack0, ack3, irq0, irq3, err0, err3;

   int errors = 0;
   int checks = 0;

   wb_resp_regfile #(.WAIT_STATES(0)) u0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we),
      .adr_i(adr), .dat_i(dat), .dat_o(dato0), .ack_o(ack0), .irq_o(irq0)
`ifdef WB_RESP_STRICT_RO_EN
      , .err_o(err0)
`endif
   );

   wb_resp_regfile #(.WAIT_STATES(3)) u3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we),
      .adr_i(adr), .dat_i(dat), .dat_o(dato3), .ack_o(ack3), .irq_o(irq3)
`ifdef WB_RESP_STRICT_RO_EN
      , .err_o(err3)
`endif
   );

`ifndef WB_RESP_STRICT_RO_EN
   assign err0 = 1'b0;
   assign err3 = 1'b0;
`endif

   // Drives one transfer on the selected instance and reports edges-to-response and whether
   // a response was still present on the edge after it.
   task automatic xfer(input bit sel, input bit w, input logic [1:0] a, input logic [7:0] d,
                       output logic [7:0] rdat, output int lat, output bit got_ack,
                       output bit got_err, output bit extra);
      @(negedge clk);
      we = w; adr = a; dat = d;
      if (sel) begin cyc3 = 1'b1; stb3 = 1'b1; end
      else     begin cyc0 = 1'b1; stb0 = 1'b1; end
      lat = 0; got_ack = 1'b0; got_err = 1'b0;
      while (!(got_ack || got_err) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         got_ack = sel ? ack3 : ack0;
         got_err = sel ? err3 : err0;
      end
      rdat = sel ? dato3 : dato0;
      if (!(got_ack || got_err)) begin
         checks++; errors++;
         $display("FAIL xfer_timeout: no response after %0d edges (adr=%0d)", lat, a);
      end
      @(posedge clk); #1;
      extra = sel ? (ack3 | err3) : (ack0 | err0);
      @(negedge clk);
      cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc0 = 1'b1; stb0 = 1'b1; cyc3 = 1'b1; stb3 = 1'b1;
      we = 1'b0; adr = 2'd3; dat = 8'h00;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", ack0); end
         checks++; if (dato0 !== 8'h00) begin errors++; $display("FAIL reset_dat0: got %h want 00", dato0); end
         checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq0: got %b want 0", irq0); end
         checks++; if (ack3 !== 1'b0) begin errors++; $display("FAIL reset_ack3: got %b want 0", ack3); end
      end
      @(negedge clk);
      rst = 1'b0; cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
      @(posedge clk); #1;
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_release_ack: got %b want 0", ack0); end
   endtask

   task automatic test_basic();
      logic [7:0] r; int lat; bit ga, ge, ex;
      xfer(0, 1, 2'd1, 8'h3C, r, lat, ga, ge, ex);
      checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_write_lat: got %0d want 1", lat); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL ws0_write_ack_len: extra ack %b want 0", ex); end
      xfer(0, 0, 2'd1, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h3C) begin errors++; $display("FAIL ws0_read_data: got %h want 3c", r); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_read_lat: got %0d want 1", lat); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL ws0_read_ack_len: extra ack %b want 0", ex); end
      xfer(0, 0, 2'd3, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'hA5) begin errors++; $display("FAIL ws0_read_id: got %h want a5", r); end
      xfer(0, 0, 2'd0, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL ws0_read_ctrl_reset: got %h want 00", r); end
   endtask

   task automatic test_wait_states();
      logic [7:0] r; int lat; bit ga, ge, ex; bit seen;
      xfer(1, 1, 2'd1, 8'h11, r, lat, ga, ge, ex);
      checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_write_lat: got %0d want 4", lat); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL ws3_write_ack_len: extra ack %b want 0", ex); end
      @(negedge clk);
      we = 1'b1; adr = 2'd1; dat = 8'h55; cyc3 = 1'b1; stb3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc3 = 1'b0; stb3 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack3) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ws3_abort_ack: got ack %b want 0", seen); end
      xfer(1, 0, 2'd1, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h11) begin errors++; $display("FAIL ws3_abort_data: got %h want 11", r); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_read_lat: got %0d want 4", lat); end
   endtask

   task automatic test_job();
      logic [7:0] r; int lat; bit ga, ge, ex;
      xfer(0, 1, 2'd0, 8'hC0, r, lat, ga, ge, ex);
      xfer(0, 0, 2'd0, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'hC0) begin errors++; $display("FAIL job_ctrl_read: got %h want c0", r); end
      xfer(0, 1, 2'd2, 8'h04, r, lat, ga, ge, ex);
      xfer(0, 0, 2'd2, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h42) begin errors++; $display("FAIL job_status_busy: got %h want 42", r); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL job_irq_early: got %b want 0", irq0); end
      @(posedge clk); #1;
      checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL job_irq_rise: got %b want 1", irq0); end
      xfer(0, 0, 2'd2, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h80) begin errors++; $display("FAIL job_status_done: got %h want 80", r); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL job_irq_fall: got %b want 0", irq0); end
      xfer(0, 0, 2'd2, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL job_status_cleared: got %h want 00", r); end
   endtask

   task automatic test_errors();
      logic [7:0] r; int lat; bit ga, ge, ex;
      xfer(0, 1, 2'd2, 8'h1F, r, lat, ga, ge, ex);
      xfer(0, 1, 2'd2, 8'hE3, r, lat, ga, ge, ex);
      xfer(0, 0, 2'd2, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h7A) begin errors++; $display("FAIL err_cmd_busy: got %h want 7a", r); end
      xfer(0, 1, 2'd0, 8'h40, r, lat, ga, ge, ex);
      xfer(0, 0, 2'd2, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL err_abort_status: got %h want 00", r); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL err_abort_irq: got %b want 0", irq0); end
      xfer(0, 1, 2'd2, 8'h02, r, lat, ga, ge, ex);
      xfer(0, 0, 2'd2, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h20) begin errors++; $display("FAIL err_cmd_disabled: got %h want 20", r); end
      xfer(0, 0, 2'd0, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'h40) begin errors++; $display("FAIL err_ctrl_read: got %h want 40", r); end
   endtask

   task automatic test_id_write();
      logic [7:0] r; int lat; bit ga, ge, ex;
      xfer(0, 1, 2'd3, 8'h12, r, lat, ga, ge, ex);
`ifdef WB_RESP_STRICT_RO_EN
      checks++; if (ge !== 1'b1) begin errors++; $display("FAIL id_write_err: got %b want 1", ge); end
      checks++; if (ga !== 1'b0) begin errors++; $display("FAIL id_write_ack: got %b want 0", ga); end
`else
      checks++; if (ga !== 1'b1) begin errors++; $display("FAIL id_write_ack: got %b want 1", ga); end
      checks++; if (ge !== 1'b0) begin errors++; $display("FAIL id_write_err: got %b want 0", ge); end
`endif
      checks++; if (lat !== 1) begin errors++; $display("FAIL id_write_lat: got %0d want 1", lat); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL id_write_len: extra resp %b want 0", ex); end
      xfer(0, 0, 2'd3, 8'h00, r, lat, ga, ge, ex);
      checks++; if (r !== 8'hA5) begin errors++; $display("FAIL id_after_write: got %h want a5", r); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_states();
      test_job();
      test_errors();
      test_id_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
